regbank_be_clr: RTL and testbench

//  Parametrised successor to the single-port-write MIPS register bank.
//  - Two synchronous read ports (A, B) and one write port (C), with per-byte write enables.
//  - Write-first bypass, so a read in the same cycle returns the new data.
//  - Optional hardwired-zero register 0.
//  - Hardware clear sequencer that zeroes the whole array without a reset.

---
 rtl/regbank_be_clr.sv | 122 ++++++++++++
 tb/tb_regbank_be_clr.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/regbank_be_clr.sv
// Two-read/one-write register bank with per-byte write enables, write-first bypass,
// optional hardwired-zero register 0 and a sequencer that clears the whole array.
module regbank_be_clr #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  R,
  input  logic [ADDR_W-1:0]     AdrA,
  input  logic [ADDR_W-1:0]     AdrB,
  input  logic                  RE,
  input  logic [ADDR_W-1:0]     AdrC,
  input  logic [DATA_W-1:0]     C,
  input  logic [DATA_W/8-1:0]   BE,
  input  logic                  W,
  input  logic                  CLR,
  output logic [DATA_W-1:0]     A,
  output logic [DATA_W-1:0]     B,
  output logic                  BUSY,
  output logic                  CLR_DONE
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  generate
    if (DATA_W % 8 != 0) begin : g_cfg_err
      $error("regbank_be_clr: DATA_W must be a multiple of 8");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   a_q, b_q;
  logic                busy_q, done_q;

  logic                wr_en;
  logic [DATA_W-1:0]   wdata_d, rd_a_d, rd_b_d;

  function automatic logic [DATA_W-1:0] merge_be(input logic [DATA_W-1:0] old_v,
                                                 input logic [DATA_W-1:0] new_v,
                                                 input logic [NB-1:0]     be);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // Writes and bypass are only live in IDLE; the merged word feeds both the array and the read ports.
  always_comb begin
    wr_en   = (state_q == S_IDLE) && W && !((ZERO_REG != 0) && (AdrC == '0));
    wdata_d = merge_be(mem_q[AdrC], C, BE);
    rd_a_d  = (wr_en && (AdrA == AdrC)) ? wdata_d : mem_q[AdrA];
    rd_b_d  = (wr_en && (AdrB == AdrC)) ? wdata_d : mem_q[AdrB];
    if ((ZERO_REG != 0) && (AdrA == '0)) rd_a_d = '0;
    if ((ZERO_REG != 0) && (AdrB == '0)) rd_b_d = '0;
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == S_CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      mem_q[AdrC] <= wdata_d;
    end
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (RE) begin
            a_q <= rd_a_d;
            b_q <= rd_b_d;
          end
          if (CLR) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign BUSY     = busy_q;
  assign CLR_DONE = done_q;

endmodule

// File: tb/tb_regbank_be_clr.sv
// Directed bench for regbank_be_clr: vector table for read/write/bypass/hold, plus
// hand sequences for clear timing, dropped writes during clear and reset mid-clear.
module tb_regbank_be_clr;

  logic        clk;
  logic        R;
  logic [4:0]  AdrA, AdrB, AdrC;
  logic        RE, W, CLR;
  logic [31:0] C;
  logic [3:0]  BE;
  logic [31:0] A, B, A0, B0;
  logic        BUSY, CLR_DONE, BUSY0, CLR_DONE0;

  int n_checks = 0;
  int n_err    = 0;

  regbank_be_clr #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .R(R), .AdrA(AdrA), .AdrB(AdrB), .RE(RE), .AdrC(AdrC), .C(C), .BE(BE),
    .W(W), .CLR(CLR), .A(A), .B(B), .BUSY(BUSY), .CLR_DONE(CLR_DONE)
  );

  regbank_be_clr #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut0 (
    .clk(clk), .R(R), .AdrA(AdrA), .AdrB(AdrB), .RE(RE), .AdrC(AdrC), .C(C), .BE(BE),
    .W(W), .CLR(CLR), .A(A0), .B(B0), .BUSY(BUSY0), .CLR_DONE(CLR_DONE0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic        re;
    logic [4:0]  aa;
    logic [4:0]  ab;
    logic [4:0]  ac;
    logic [31:0] c;
    logic [3:0]  be;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] ea0;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    W = 0; RE = 0; CLR = 0; AdrA = 0; AdrB = 0; AdrC = 0; C = 0; BE = 0;
  endtask

  task automatic fill_all();
    for (int i = 0; i < 32; i++) begin
      W = 1; AdrC = 5'(i); C = 32'hA5A50000 | 32'(i + 1); BE = 4'hF;
      step();
    end
    W = 0;
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      RE = 1; AdrA = 5'(i); AdrB = 5'(31 - i);
      step();
      chk($sformatf("%s_A%0d", tag, i), A, 32'h0);
      chk($sformatf("%s_B%0d", tag, 31 - i), B, 32'h0);
      chk($sformatf("%s_A0_%0d", tag, i), A0, 32'h0);
    end
    RE = 0;
  endtask

  initial begin
    int busy_cnt, done_cnt, done_cyc;
    logic [31:0] a_before;

    tbl[0] = '{1'b1, 1'b1, 5'd5,  5'd0,  5'd5,  32'h11223344, 4'hF,    32'h11223344, 32'h0,        32'h11223344};
    tbl[1] = '{1'b1, 1'b1, 5'd5,  5'd5,  5'd5,  32'hAABBCCDD, 4'b0101, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD};
    tbl[2] = '{1'b0, 1'b1, 5'd5,  5'd3,  5'd0,  32'h0,        4'h0,    32'h11BB33DD, 32'h0,        32'h11BB33DD};
    tbl[3] = '{1'b1, 1'b1, 5'd3,  5'd5,  5'd3,  32'hCAFEF00D, 4'b1000, 32'hCA000000, 32'h11BB33DD, 32'hCA000000};
    tbl[4] = '{1'b1, 1'b1, 5'd3,  5'd3,  5'd3,  32'h12345678, 4'b0000, 32'hCA000000, 32'hCA000000, 32'hCA000000};
    tbl[5] = '{1'b1, 1'b1, 5'd0,  5'd0,  5'd0,  32'hFFFFFFFF, 4'hF,    32'h0,        32'h0,        32'hFFFFFFFF};
    tbl[6] = '{1'b0, 1'b1, 5'd0,  5'd31, 5'd0,  32'h0,        4'h0,    32'h0,        32'h0,        32'hFFFFFFFF};
    tbl[7] = '{1'b1, 1'b0, 5'd31, 5'd31, 5'd31, 32'hDEADBEEF, 4'hF,    32'h0,        32'h0,        32'hFFFFFFFF};
    tbl[8] = '{1'b0, 1'b1, 5'd31, 5'd5,  5'd0,  32'h0,        4'h0,    32'hDEADBEEF, 32'h11BB33DD, 32'hDEADBEEF};

    idle_inputs();
    R = 0;
    #2;
    chk("rst_A", A, 32'h0);
    chk("rst_B", B, 32'h0);
    chk("rst_BUSY", 32'(BUSY), 32'h0);
    chk("rst_DONE", 32'(CLR_DONE), 32'h0);
    #10;
    R = 1;
    step();
    read_all_zero("post_rst");

    for (int i = 0; i < 9; i++) begin
      W = tbl[i].w; RE = tbl[i].re; AdrA = tbl[i].aa; AdrB = tbl[i].ab;
      AdrC = tbl[i].ac; C = tbl[i].c; BE = tbl[i].be;
      step();
      chk($sformatf("vec%0d_A", i), A, tbl[i].ea);
      chk($sformatf("vec%0d_B", i), B, tbl[i].eb);
      chk($sformatf("vec%0d_A_z0", i), A0, tbl[i].ea0);
      chk($sformatf("vec%0d_BUSY", i), 32'(BUSY), 32'h0);
    end
    idle_inputs();

    // Full clear with a write coincident with CLR and another mid-clear
    fill_all();
    RE = 1; AdrA = 5'd7; AdrB = 5'd9;
    step();
    chk("pre_clr_A", A, 32'hA5A50008);
    chk("pre_clr_B", B, 32'hA5A5000A);
    a_before = A;
    RE = 0;
    CLR = 1; W = 1; AdrC = 5'd9; C = 32'h0BADF00D; BE = 4'hF;
    step();
    CLR = 0; W = 0;
    busy_cnt = 0; done_cnt = 0; done_cyc = 0;
    for (int k = 0; k < 100; k++) begin
      if (!BUSY) break;
      busy_cnt++;
      if (CLR_DONE) begin
        done_cnt++;
        done_cyc = busy_cnt;
      end
      RE = 1; AdrA = 5'(k); AdrB = 5'(k);
      CLR = (k == 20);
      if (k == 5) begin
        W = 1; AdrC = 5'd2; C = 32'hFFFFFFFF; BE = 4'hF;
      end else begin
        W = 0;
      end
      step();
    end
    idle_inputs();
    chk("clr_busy_len", 32'(busy_cnt), 32'd33);
    chk("clr_done_cnt", 32'(done_cnt), 32'd1);
    chk("clr_done_cyc", 32'(done_cyc), 32'd33);
    chk("clr_hold_A", A, a_before);
    chk("clr_hold_B", B, 32'hA5A5000A);
    read_all_zero("post_clr");

    // Reset in the middle of a clear
    fill_all();
    RE = 1; AdrA = 5'd20; AdrB = 5'd21;
    step();
    chk("pre_rst_A", A, 32'hA5A50015);
    RE = 0; CLR = 1;
    step();
    CLR = 0;
    for (int k = 1; k < 10; k++) step();
    chk("midclr_BUSY", 32'(BUSY), 32'h1);
    #2;
    R = 0;
    #1;
    chk("midrst_A", A, 32'h0);
    chk("midrst_B", B, 32'h0);
    chk("midrst_BUSY", 32'(BUSY), 32'h0);
    chk("midrst_DONE", 32'(CLR_DONE), 32'h0);
    #10;
    R = 1;
    step();
    chk("rel_BUSY", 32'(BUSY), 32'h0);
    read_all_zero("post_midrst");
    chk("idle_BUSY", 32'(BUSY), 32'h0);
    chk("idle_DONE", 32'(CLR_DONE), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
